// File: rtl/ingress_frame_arbiter_pkg.sv
// Shared types and register map for the ingress frame arbiter.
//   arb_state_e     : arbiter FSM states
//   ARB_REG_*       : Avalon-MM register addresses
package pf_arb_pkg;

  typedef enum logic {IDLE, XFER} arb_state_e;

  localparam logic [7:0] ARB_REG_ENABLE   = 8'd0;
  localparam logic [7:0] ARB_REG_GRANT    = 8'd1;
  localparam logic [7:0] ARB_REG_CNT_BASE = 8'd2;
  localparam logic [7:0] ARB_REG_CLEAR    = 8'd15;

endpackage

// File: rtl/ingress_frame_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per port
//   pointer : last granted port; search starts at pointer+1 and wraps
//   valid   : at least one request is set
//   index   : selected port
module rr_picker #(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     pointer,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest
  // requester after the pointer is the one left standing.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = IDX_W'((int'(pointer) + k) % NUM_PORTS);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// Frame-level round-robin arbiter: NUM_PORTS AXI-Stream sources share one
// output stream. A source holds the grant from arbitration until its tlast
// beat is accepted, so frames are never interleaved.
//   clk, reset                 : clock, synchronous active-high reset
//   chipselect/write/read/
//   address/writedata/readdata : Avalon-MM register slave (enable mask,
//                                grant/busy status, frame counters, clear)
//   s_tdata/s_tvalid/s_tlast/
//   s_tready                   : per-source stream inputs
//   m_tdata/m_tvalid/m_tlast/
//   m_tready                   : shared stream output
module ingress_frame_arbiter
  import pf_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            chipselect,
  input  logic                            write,
  input  logic                            read,
  input  logic [7:0]                      address,
  input  logic [7:0]                      writedata,
  output logic [7:0]                      readdata,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e                          state, state_next;
  logic [IDX_W-1:0]                    grant, pointer, pick_idx;
  logic                                pick_valid, frame_done;
  logic [NUM_PORTS-1:0]                enable;
  logic [NUM_PORTS-1:0][7:0]           frame_cnt;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] lanes;
  logic [7:0]                          rd_next, cnt_off;
  logic                                reg_wr, reg_rd, cnt_hit, cnt_clear;

  assign lanes     = s_tdata;
  assign reg_wr    = chipselect && write;
  assign reg_rd    = chipselect && read;
  assign cnt_clear = reg_wr && (address == ARB_REG_CLEAR);

  // The enable mask only gates new arbitration; an in-flight frame ignores it.
  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req     (s_tvalid & enable),
    .pointer (pointer),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      pointer <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && pick_valid) grant <= pick_idx;
      if (frame_done) pointer <= grant;
    end
  end

  always_comb begin
    state_next = state;
    m_tdata    = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    s_tready   = '0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (pick_valid) state_next = XFER;
      XFER: begin
        m_tdata         = lanes[grant];
        m_tvalid        = s_tvalid[grant];
        m_tlast         = s_tlast[grant];
        s_tready[grant] = m_tready;
        if (m_tvalid && m_tready && m_tlast) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear has priority over a coincident frame completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable    <= '1;
      frame_cnt <= '0;
    end else begin
      if (reg_wr && address == ARB_REG_ENABLE) enable <= writedata[NUM_PORTS-1:0];
      if (cnt_clear)       frame_cnt        <= '0;
      else if (frame_done) frame_cnt[grant] <= frame_cnt[grant] + 8'd1;
    end
  end

  assign cnt_off = address - ARB_REG_CNT_BASE;
  assign cnt_hit = (address >= ARB_REG_CNT_BASE) &&
                   (address < 8'(int'(ARB_REG_CNT_BASE) + NUM_PORTS));

  always_comb begin
    rd_next = '0;
    if (reg_rd) begin
      if (address == ARB_REG_ENABLE) begin
        rd_next[NUM_PORTS-1:0] = enable;
      end else if (address == ARB_REG_GRANT) begin
        rd_next[7]         = (state == XFER);
        rd_next[IDX_W-1:0] = grant;
      end else if (cnt_hit) begin
        rd_next = frame_cnt[cnt_off[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule

// File: doc/ingress_frame_arbiter.md
Name: ingress_frame_arbiter

Overview:
- Frame-level round-robin arbiter that shares one 16-bit AXI-Stream ingress path between NUM_PORTS upstream sources.
- Sits between the MAC-side stream sources and frame_receptor.
- Grants one source per frame and switches only on tlast, so frames are never interleaved.
- Avalon-MM slave provides the enable mask, current-grant readback and per-port frame counters.

Parameters:
- NUM_PORTS, 4, number of upstream stream sources; legal range 2..8.
- DATA_WIDTH, 16, stream data width per port.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon-MM chip select
- write  in  1  Avalon-MM write strobe
- read  in  1  Avalon-MM read strobe
- address  in  8  Avalon-MM register address
- writedata  in  8  Avalon-MM write data
- readdata  out  8  Avalon-MM read data, registered
- s_tdata  in  NUM_PORTS*DATA_WIDTH  source data; port i occupies bits [i*16 +: 16]
- s_tvalid  in  NUM_PORTS  per-source valid
- s_tlast  in  NUM_PORTS  per-source end of frame
- s_tready  out  NUM_PORTS  per-source ready
- m_tdata  out  DATA_WIDTH  data to frame_receptor
- m_tvalid  out  1  valid to frame_receptor
- m_tlast  out  1  end of frame to frame_receptor
- m_tready  in  1  ready from frame_receptor

Behaviour:
- Register map (R = read, W = write):
  - 0 R/W: enable mask; bit i enables port i; bits at or above NUM_PORTS read 0.
  - 1 R: bit 7 = busy (state is XFER), bits [2:0] = current grant.
  - 2..(2+NUM_PORTS-1) R: per-port frame counters.
  - 15 W: writing any value clears all frame counters.
  - Reads of any other address return 0x00.
- readdata:
  - Updated one cycle after chipselect && read.
  - Returns 0x00 on any cycle without chipselect && read.
- Reset values:
  - enable mask = 0xFF, truncated to NUM_PORTS bits.
  - Frame counters = 0; readdata = 0; state = IDLE.
  - Grant pointer = NUM_PORTS-1, so port 0 wins the first arbitration.
- States: IDLE, XFER.
- IDLE:
  - req[i] = s_tvalid[i] & enable[i].
  - If req is non-zero, select the first set bit searching from (grant pointer + 1), wrapping modulo NUM_PORTS.
  - Register the selection as grant and move to XFER on the next edge.
  - m_tvalid = 0 and all s_tready = 0 while in IDLE.
- XFER, combinational pass-through, no added latency:
  - m_tdata = s_tdata[grant]; m_tlast = s_tlast[grant].
  - m_tvalid = s_tvalid[grant].
  - s_tready[grant] = m_tready; every other s_tready = 0.
  - A beat is accepted when m_tvalid && m_tready.
  - On an accepted beat with m_tlast = 1: increment frame_counter[grant], grant pointer becomes grant, return to IDLE.
- Inter-frame gap: exactly 1 idle cycle (the IDLE arbitration cycle) between frames.
- Frame counters are 8-bit and wrap 255 -> 0.
- Counter clear and tlast in the same cycle: clear wins; the counter reads 0.
- Enable mask is applied at arbitration only:
  - Clearing the granted port's enable bit mid-frame does not abort the frame.
  - That port is not granted again until it is re-enabled.
- Enable mask = 0: the block stays in IDLE; no grants are issued.
- s_tvalid[grant] dropping mid-frame: the block holds the grant and waits indefinitely; there is no timeout.
- Reset mid-frame: back to IDLE and grant pointer = NUM_PORTS-1 on the next edge; the partial frame is truncated (no tlast is emitted).
- m_tready low: the beat stalls with the source holding it; m_tdata/m_tvalid follow the source unchanged.

Decomposition:
- Package pf_arb_pkg:
  - arb_state_e enum {IDLE, XFER}.
  - Register address localparams: ARB_REG_ENABLE=0, ARB_REG_GRANT=1, ARB_REG_CNT_BASE=2, ARB_REG_CLEAR=15.
- Sub-module rr_picker: purely combinational (req, pointer) -> (valid, index), parameterised by NUM_PORTS.
- The top level holds the FSM, counters, register file and output mux.

Test Plan:
- Reset, then port 0 sends a 4-beat frame with m_tready=1 -> m_tvalid high for 4 cycles starting the cycle after IDLE; addr 2 reads 0x01; addr 1 reads 0x00.
- Ports 0..3 all valid, 2-beat frames each -> grant order 0,1,2,3,0 with one idle cycle between frames; no interleaved beats.
- Write 0x05 to addr 0, all ports valid -> only ports 0 and 2 are granted, alternating; addr 3 and addr 5 stay 0.
- Mid-frame on port 1: m_tready toggles 1,0,1 and s_tvalid[1] drops for 3 cycles -> grant stays 1, no beat lost or duplicated, tlast ends the frame; addr 1 bit 7 reads 1 during the frame.
- Send 256 frames on port 2 -> addr 4 reads 0x00 (wrap); then write addr 15 on the same cycle as a port 2 tlast -> addr 4 reads 0x00.
- Assert reset on beat 2 of a 5-beat port-3 frame -> m_tvalid=0 the next cycle; the following arbitration with ports 0 and 3 valid grants port 0.
